weight_pack_mem: RTL
====================

# weight_pack_mem

Parametrised weight local memory for the CNN accelerator: accepts a serial stream of DATA_W-bit weights from the weight loader, packs them lane-by-lane into LANES-wide rows of an internal DEPTH-row array, and serves two independent registered read ports to the PE array. Per-layer lane count and row count are runtime-configured, so one instance covers 3-channel first layers, 8-channel middle layers, and the fully-connected layer. A store sequence is started, tracked and completed by an internal FSM with a ready/valid write handshake.

## Interface
- DATA_W, 16, bits per weight lane
- LANES, 8, lanes per row; row width = LANES*DATA_W
- DEPTH, 80, number of rows
- ADDR_W, 7, row address width; requires 2**ADDR_W >= DEPTH
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- cfg_start  in  1  one-cycle pulse; latches cfg_lanes/cfg_last_row and begins a store sequence
- cfg_lanes  in  4  active lanes per row, 1..LANES
- cfg_last_row  in  ADDR_W  index of the final row of the sequence
- wr_valid  in  1  wr_data valid
- wr_data  in  DATA_W  weight word
- wr_ready  out  1  block accepts a word this cycle
- busy  out  1  store sequence in progress
- store_done  out  1  one-cycle pulse after the final word is written
- rd_en_a, rd_en_b  in  1  read request, ports A/B
- rd_addr_a, rd_addr_b  in  ADDR_W  row address, ports A/B
- rd_data_a, rd_data_b  out  LANES*DATA_W  registered row data; lane k occupies bits [k*DATA_W +: DATA_W]

## Operation
- FSM states: IDLE, FILL, DONE.
- IDLE: wr_ready=0, busy=0. cfg_start -> FILL; lane_cnt=0, row_cnt=0; cfg latched.
- Config sanitising at latch: cfg_lanes==0 or >LANES -> LANES; cfg_last_row>=DEPTH -> DEPTH-1.
- FILL: wr_ready=1, busy=1. Each wr_valid&&wr_ready writes wr_data into lane lane_cnt of row row_cnt.
  - Write to lane 0 writes the whole row: wr_data in lane 0, all other lanes zero (stale lanes from a wider previous layer are cleared). Writes to lane k>0 write only lane k.
  - lane_cnt increments; at lane_cnt==cfg_lanes-1 it wraps to 0 and row_cnt increments.
  - Word with lane_cnt==cfg_lanes-1 and row_cnt==cfg_last_row is final -> DONE.
  - wr_valid low: no write, counters hold.
- DONE: one cycle; store_done=1, wr_ready=0, busy=0 -> IDLE.
- cfg_start in FILL or DONE: aborts current sequence, relatches cfg, counters cleared, FILL next cycle; no store_done for the aborted sequence. A word presented the same cycle as cfg_start is not written.
- Reads: independent of FSM state. rd_en high samples the row at the edge; rd_en low holds rd_data. Address >=DEPTH reads row 0.
- Read of the row being written in the same cycle returns pre-write contents.
- Array contents are not reset; rows never written read undefined.

## Timing
- Reset (rst low, asynchronous): state=IDLE, counters=0, wr_ready=0, busy=0, store_done=0, rd_data_a=rd_data_b=0. Reset mid-FILL discards the sequence; rows already written keep their contents.
- wr_ready rises the cycle after cfg_start; one word per cycle at full throughput.
- Store of R=cfg_last_row+1 rows with L lanes at full rate: final word accepted L*R cycles after wr_ready rises; store_done high the following cycle.
- Write visible to a read issued the cycle after the write edge.
- Read latency 1: rd_en at edge n -> rd_data valid after edge n, held until next enabled read.
- Both ports may read the same or different rows in the same cycle.

## Test plan
- 3-lane layer: cfg_lanes=3, cfg_last_row=71, stream words 1..216 -> store_done one cycle after the 216th word; row 5 reads lanes {16,17,18}, lanes 3..7 zero.
- 8-lane over 3-lane: after the previous fill, cfg_lanes=8, cfg_last_row=49, words 1000..1399 -> row 0 = {1007..1000}; row 60 unchanged from previous fill.
- Bubbles and abort: toggle wr_valid 50% in FILL -> counters advance only on accepted words; cfg_start after 10 words -> restart at row 0 lane 0, no store_done.
- Read ports: rd_addr_a=5, rd_addr_b=90 same cycle -> A returns row 5, B returns row 0, both after one edge; rd_en low holds values.
- Collision: read row r on the edge it is written -> old value; re-read next cycle -> new value.
- Reset mid-FILL: assert rst asynchronously between edges -> outputs zero immediately, wr_ready=0; cfg_lanes=0 then 9 after release -> treated as 8 lanes.

Source files
------------

// File: rtl/weight_pack_mem_if.sv
// Serial weight write stream from the weight loader into weight_pack_mem.
// The loader drives master; the memory block is the slave.
interface weight_pack_mem_if #(
  parameter int DATA_W = 16
);
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/weight_pack_mem.sv
// Weight local memory: packs a serial weight stream lane-by-lane into
// LANES-wide rows and serves two independent registered row read ports.
module weight_pack_mem #(
  parameter int DATA_W = 16,
  parameter int LANES  = 8,
  parameter int DEPTH  = 80,
  parameter int ADDR_W = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_start,
  input  logic [3:0]                cfg_lanes,
  input  logic [ADDR_W-1:0]         cfg_last_row,
  weight_pack_mem_if.slave          wr,
  output logic                      busy,
  output logic                      store_done,
  input  logic                      rd_en_a,
  input  logic [ADDR_W-1:0]         rd_addr_a,
  output logic [LANES*DATA_W-1:0]   rd_data_a,
  input  logic                      rd_en_b,
  input  logic [ADDR_W-1:0]         rd_addr_b,
  output logic [LANES*DATA_W-1:0]   rd_data_b
);

  localparam logic [3:0]        LANES_CFG    = 4'(LANES);
  localparam logic [ADDR_W:0]   DEPTH_EXT    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ROW_MAX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          lane_cnt_reg;
  logic [ADDR_W-1:0]   row_cnt_reg;
  logic [3:0]          cfg_lanes_reg;
  logic [ADDR_W-1:0]   cfg_last_row_reg;
  logic [3:0]          cfg_lanes_san;
  logic [ADDR_W-1:0]   cfg_last_row_san;
  logic                wr_fire;
  logic                last_lane;
  logic                final_word;
  logic [ADDR_W-1:0]   rd_row_a, rd_row_b;

  // Out-of-range layer configs fall back to the full row width / last row.
  always_comb begin
    cfg_lanes_san    = (cfg_lanes == 4'd0 || cfg_lanes > LANES_CFG) ? LANES_CFG : cfg_lanes;
    cfg_last_row_san = ({1'b0, cfg_last_row} >= DEPTH_EXT) ? LAST_ROW_MAX : cfg_last_row;
    rd_row_a         = ({1'b0, rd_addr_a} < DEPTH_EXT) ? rd_addr_a : '0;
    rd_row_b         = ({1'b0, rd_addr_b} < DEPTH_EXT) ? rd_addr_b : '0;
  end

  // A word coinciding with cfg_start belongs to the aborted sequence.
  assign wr_fire    = wr.wr_ready && wr.wr_valid && !cfg_start;
  assign last_lane  = (lane_cnt_reg == cfg_lanes_reg - 4'd1);
  assign final_word = wr_fire && last_lane && (row_cnt_reg == cfg_last_row_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    wr.wr_ready = 1'b0;
    busy        = 1'b0;
    store_done  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cfg_start) state_next = FILL;
      end
      FILL: begin
        wr.wr_ready = 1'b1;
        busy        = 1'b1;
        if (cfg_start)       state_next = FILL;
        else if (final_word) state_next = DONE;
      end
      DONE: begin
        store_done = 1'b1;
        state_next = cfg_start ? FILL : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_cnt_reg     <= '0;
      row_cnt_reg      <= '0;
      cfg_lanes_reg    <= LANES_CFG;
      cfg_last_row_reg <= '0;
    end else if (cfg_start) begin
      lane_cnt_reg     <= '0;
      row_cnt_reg      <= '0;
      cfg_lanes_reg    <= cfg_lanes_san;
      cfg_last_row_reg <= cfg_last_row_san;
    end else if (wr_fire) begin
      if (last_lane) begin
        lane_cnt_reg <= '0;
        row_cnt_reg  <= row_cnt_reg + 1'b1;
      end else begin
        lane_cnt_reg <= lane_cnt_reg + 4'd1;
      end
    end
  end

  // One narrow array per lane so a lane-k write leaves the other lanes intact;
  // a lane-0 write zeroes the rest of the row to clear stale wider-layer data.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [DATA_W-1:0] lane_mem [DEPTH];
      logic [DATA_W-1:0] rd_lane_a_reg, rd_lane_b_reg;
      logic              lane_we;
      logic              lane_sel;

      assign lane_sel = (lane_cnt_reg == 4'(gi));
      assign lane_we  = wr_fire && (lane_sel || lane_cnt_reg == 4'd0);

      always_ff @(posedge clk) begin
        if (lane_we) lane_mem[row_cnt_reg] <= lane_sel ? wr.wr_data : '0;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_lane_a_reg <= '0;
          rd_lane_b_reg <= '0;
        end else begin
          if (rd_en_a) rd_lane_a_reg <= lane_mem[rd_row_a];
          if (rd_en_b) rd_lane_b_reg <= lane_mem[rd_row_b];
        end
      end

      assign rd_data_a[gi*DATA_W +: DATA_W] = rd_lane_a_reg;
      assign rd_data_b[gi*DATA_W +: DATA_W] = rd_lane_b_reg;
    end
  endgenerate

endmodule
